// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates main memory between I-cache and D-cache miss handlers
// Grants one side at a time; runs 8-word pipelined line fills or single-word writes.
module mem_arbiter #(
  parameter int MEM_LAT    = 4,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        i_grant,
  output logic        d_grant,
  output logic [15:0] fill_data,
  output logic        i_fill_valid,
  output logic        d_fill_valid,
  output logic [2:0]  fill_idx,
  output logic        i_done,
  output logic        d_done,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid
);

  if (LINE_WORDS != 8 || MEM_LAT < 1) begin : g_cfg_check
    $error("mem_arbiter: LINE_WORDS must be 8 and MEM_LAT at least 1");
  end

  localparam logic [2:0] LAST_WORD = 3'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WRITE} state_t;

  state_t      state_q, state_d;
  logic        i_grant_q, i_grant_d;
  logic        d_grant_q, d_grant_d;
  logic        last_q, last_d;
  logic [2:0]  icnt_q, icnt_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [11:0] line_q, line_d;
  logic        pick_i, pick_d;
  logic        fill_v;
  logic        unused_ok;

  assign unused_ok = ^{i_addr[3:0], d_addr[0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      i_grant_q <= 1'b0;
      d_grant_q <= 1'b0;
      last_q    <= 1'b0;
      icnt_q    <= 3'd0;
      rcnt_q    <= 4'd0;
      line_q    <= 12'd0;
    end else begin
      state_q   <= state_d;
      i_grant_q <= i_grant_d;
      d_grant_q <= d_grant_d;
      last_q    <= last_d;
      icnt_q    <= icnt_d;
      rcnt_q    <= rcnt_d;
      line_q    <= line_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_grant_d = i_grant_q;
    d_grant_d = d_grant_q;
    last_d    = last_q;
    icnt_d    = icnt_q;
    rcnt_d    = rcnt_q;
    line_d    = line_q;
    pick_d    = 1'b0;
    pick_i    = 1'b0;
    fill_v    = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'd0;
    mem_wdata = 16'd0;

    unique case (state_q)
      IDLE: begin
        // Under contention the side that did not win last time gets the memory.
        pick_d = d_req && (!i_req || !last_q);
        pick_i = i_req && !pick_d;
        if (pick_i || pick_d) begin
          i_grant_d = pick_i;
          d_grant_d = pick_d;
          last_d    = pick_d;
          if (pick_d && d_wr) begin
            state_d = WRITE;
          end else begin
            line_d  = pick_d ? d_addr[15:4] : i_addr[15:4];
            icnt_d  = 3'd0;
            rcnt_d  = 4'd0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = {line_q, icnt_q, 1'b0};
        icnt_d   = icnt_q + 3'd1;
        if (icnt_q == LAST_WORD) state_d = DRAIN;
      end
      DRAIN: ;
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {d_addr[15:1], 1'b0};
        mem_wdata = d_wdata;
        state_d   = IDLE;
        i_grant_d = 1'b0;
        d_grant_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Returning words are only accepted while a fill is in flight.
    if ((state_q == ISSUE || state_q == DRAIN) && mem_valid) begin
      fill_v = 1'b1;
      rcnt_d = rcnt_q + 4'd1;
      if (rcnt_q[2:0] == LAST_WORD) begin
        state_d   = IDLE;
        i_grant_d = 1'b0;
        d_grant_d = 1'b0;
      end
    end
  end

  assign i_grant      = i_grant_q;
  assign d_grant      = d_grant_q;
  assign fill_data    = mem_rdata;
  assign i_fill_valid = fill_v && i_grant_q;
  assign d_fill_valid = fill_v && d_grant_q;
  assign fill_idx     = fill_v ? rcnt_q[2:0] : 3'd0;
  assign i_done       = i_fill_valid && (fill_idx == LAST_WORD);
  assign d_done       = (d_fill_valid && (fill_idx == LAST_WORD)) || (state_q == WRITE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a latency-pipelined memory model
module tb_mem_arbiter;
  localparam int MEM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, d_grant, i_fill_valid, d_fill_valid, i_done, d_done;
  logic        mem_en, mem_wr, mem_valid;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  fill_idx;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_wr(d_wr),
    .d_addr(d_addr), .d_wdata(d_wdata), .i_grant(i_grant), .d_grant(d_grant),
    .fill_data(fill_data), .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .fill_idx(fill_idx), .i_done(i_done), .d_done(d_done), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Memory model: read data appears MEM_LAT cycles after the issuing cycle.
  logic [MEM_LAT-1:0] pv;
  logic [15:0]        pa [MEM_LAT];
  logic               inj;
  always @(posedge clk) begin
    if (!rst) pv <= '0;
    else      pv <= {pv[MEM_LAT-2:0], mem_en && !mem_wr};
    pa[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) pa[i] <= pa[i-1];
  end
  assign mem_valid = pv[MEM_LAT-1] | inj;
  assign mem_rdata = pv[MEM_LAT-1] ? memf(pa[MEM_LAT-1]) : 16'h0000;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic s; logic [2:0] idx; logic [15:0] d; } fill_t;
  typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;
  typedef struct packed { logic s; logic [31:0] c; } done_t;

  logic [15:0] rdq [$];
  fill_t       fq  [$];
  wr_t         wrq [$];
  done_t       dq  [$];

  int checks = 0, failures = 0, timeouts = 0;
  bit chk_zero = 0, fin = 0, last_g = 0;

  // Monitor / scoreboard.
  initial begin
    fill_t f; wr_t w; done_t dn; logic [15:0] ea; logic [42:0] zr;
    forever begin
      @(negedge clk);
      if (chk_zero) begin
        checks++;
        zr = {i_grant, d_grant, i_fill_valid, d_fill_valid, fill_idx, i_done, d_done,
              mem_en, mem_wr, mem_addr, mem_wdata};
        if (zr != '0) begin failures++; $display("FAIL zero_outputs cyc=%0d got=%h want=0", cyc, zr); end
      end
      if (mem_en && !mem_wr) begin
        checks++;
        if (rdq.size() == 0) begin failures++; $display("FAIL read_unexpected cyc=%0d addr=%h", cyc, mem_addr); end
        else begin
          ea = rdq.pop_front();
          if (mem_addr !== ea) begin failures++; $display("FAIL read_addr cyc=%0d got=%h want=%h", cyc, mem_addr, ea); end
        end
      end
      if (mem_en && mem_wr) begin
        checks++;
        if (wrq.size() == 0) begin failures++; $display("FAIL write_unexpected cyc=%0d addr=%h", cyc, mem_addr); end
        else begin
          w = wrq.pop_front();
          if ({mem_addr, mem_wdata, d_grant, i_grant} !== {w.a, w.d, 2'b10})
            begin failures++; $display("FAIL write cyc=%0d got=%h/%h g=%b%b want=%h/%h g=10", cyc, mem_addr, mem_wdata, d_grant, i_grant, w.a, w.d); end
        end
      end
      if (i_fill_valid || d_fill_valid) begin
        checks++;
        if (fq.size() == 0) begin failures++; $display("FAIL fill_unexpected cyc=%0d iv=%b dv=%b", cyc, i_fill_valid, d_fill_valid); end
        else begin
          f = fq.pop_front();
          if ({i_fill_valid, d_fill_valid, i_grant, d_grant, fill_idx, fill_data} !==
              {~f.s, f.s, ~f.s, f.s, f.idx, f.d})
            begin failures++; $display("FAIL fill cyc=%0d got v=%b%b g=%b%b idx=%0d d=%h want side=%0d idx=%0d d=%h",
              cyc, i_fill_valid, d_fill_valid, i_grant, d_grant, fill_idx, fill_data, f.s, f.idx, f.d); end
        end
      end
      if (i_done || d_done) begin
        checks++;
        if (dq.size() == 0) begin failures++; $display("FAIL done_unexpected cyc=%0d i=%b d=%b", cyc, i_done, d_done); end
        else begin
          dn = dq.pop_front();
          if ({i_done, d_done, 32'(cyc)} !== {~dn.s, dn.s, dn.c})
            begin failures++; $display("FAIL done cyc=%0d i=%b d=%b want side=%0d at cyc=%0d", cyc, i_done, d_done, dn.s, dn.c); end
        end
      end
      if (fin) begin
        checks++;
        if (rdq.size() + fq.size() + wrq.size() + dq.size() + timeouts != 0)
          begin failures++; $display("FAIL leftovers rd=%0d fill=%0d wr=%0d done=%0d timeouts=%0d want all 0",
            rdq.size(), fq.size(), wrq.size(), dq.size(), timeouts); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference model: a granted transaction produces its memory ops, words and done at fixed offsets.
  task automatic push_side(input bit s, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                           input int grant_cyc, output int done_cyc);
    logic [15:0] ra;
    if (wr) begin
      wrq.push_back('{a: {a[15:1], 1'b0}, d: wd});
      done_cyc = grant_cyc;
    end else begin
      for (int k = 0; k < 8; k++) begin
        ra = {a[15:4], 3'(k), 1'b0};
        rdq.push_back(ra);
        fq.push_back('{s: s, idx: 3'(k), d: memf(ra)});
      end
      done_cyc = grant_cyc + 7 + MEM_LAT;
    end
    dq.push_back('{s: s, c: 32'(done_cyc)});
    last_g = s;
  endtask

  task automatic run_txn(input bit ui, input bit ud, input bit dw, input logic [15:0] ia,
                         input logic [15:0] da, input logic [15:0] wd, input int drop_at);
    int start, dn; bit ip, dp;
    @(posedge clk); #1;
    start = cyc;
    if (ui && ud) begin
      if (last_g) begin push_side(0, 0, ia, 0, start + 1, dn); push_side(1, dw, da, wd, dn + 2, dn); end
      else        begin push_side(1, dw, da, wd, start + 1, dn); push_side(0, 0, ia, 0, dn + 2, dn); end
    end else if (ui) push_side(0, 0, ia, 0, start + 1, dn);
    else if (ud)     push_side(1, dw, da, wd, start + 1, dn);
    i_req = ui; i_addr = ia; d_req = ud; d_wr = dw; d_addr = da; d_wdata = wd;
    ip = ui; dp = ud;
    for (int t = 0; t < 300 && (ip || dp); t++) begin
      @(negedge clk);
      if (i_done) begin ip = 0; i_req = 0; end
      if (d_done) begin dp = 0; d_req = 0; end
      if (cyc - start == drop_at) i_req = 0;
    end
    if (ip || dp) begin timeouts++; i_req = 0; d_req = 0; end
  endtask

  initial begin
    int start; logic [15:0] ia; logic [15:0] ra;
    rst = 0; i_req = 0; d_req = 0; d_wr = 0; i_addr = 0; d_addr = 0; d_wdata = 0; inj = 0;
    repeat (2) @(posedge clk);
    #1 chk_zero = 1;
    @(posedge clk); #1 rst = 1; chk_zero = 0;

    run_txn(1, 0, 0, 16'h1234, 16'h0, 16'h0, -1);
    run_txn(0, 1, 1, 16'h0, 16'h0041, 16'hBEEF, -1);

    @(posedge clk); #1 rst = 0; last_g = 0;
    @(posedge clk); #1 rst = 1;
    run_txn(1, 1, 0, 16'h4567, 16'h89AB, 16'h0, -1);
    run_txn(1, 1, 0, 16'hC0DE, 16'h7770, 16'h0, -1);

    // Reset in cycle 6 of an I fill: only words issued/returned before it are seen.
    @(posedge clk); #1;
    start = cyc; ia = 16'($urandom);
    for (int k = 0; k < 6; k++) rdq.push_back({ia[15:4], 3'(k), 1'b0});
    for (int k = 0; k < 2; k++) begin
      ra = {ia[15:4], 3'(k), 1'b0};
      fq.push_back('{s: 1'b0, idx: 3'(k), d: memf(ra)});
    end
    i_addr = ia; i_req = 1;
    while (cyc - start < 6) begin @(posedge clk); #1; end
    rst = 0;
    @(posedge clk); #1 rst = 1; i_req = 0; chk_zero = 1; last_g = 0;
    @(posedge clk); #1 chk_zero = 0;
    run_txn(0, 1, 0, 16'h0, 16'h3A5F, 16'h0, -1);

    run_txn(1, 0, 0, 16'hF00D, 16'h0, 16'h0, 3);
    @(posedge clk); #1 inj = 1; chk_zero = 1;
    repeat (2) begin @(posedge clk); #1; end
    inj = 0; chk_zero = 0;

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: run_txn(1, 0, 0, 16'($urandom), 16'($urandom), 16'($urandom), -1);
        1: run_txn(0, 1, 0, 16'($urandom), 16'($urandom), 16'($urandom), -1);
        2: run_txn(0, 1, 1, 16'($urandom), 16'($urandom), 16'($urandom), -1);
        default: run_txn(1, 1, 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), -1);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (MEM_LAT + 2) @(posedge clk);
    fin = 1;
    repeat (20) @(posedge clk);
  end
endmodule
